// File: rtl/mem_bus_adapter.sv
// Bus master that turns one byte/half/word memory op into a single 32-bit
// bus transaction, with lane steering, read extension, fault and timeout reporting.
module mem_bus_adapter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_write,
  input  logic        is_unsigned,
  input  logic [1:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        error,
  output logic        bus_req,
  output logic        bus_we,
  output logic [29:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic        bus_err,
  input  logic [31:0] bus_rdata
);

  localparam logic [1:0] OP_BYTE = 2'b00;
  localparam logic [1:0] OP_HALF = 2'b01;
  localparam logic [1:0] OP_WORD = 2'b10;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_FINISH} state_e;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [1:0]        op_q;
  logic [1:0]        lane_q;
  logic              uns_q;
  logic              busy_q, done_q, error_q;
  logic [31:0]       rdata_q;
  logic              bus_req_q, bus_we_q;
  logic [29:0]       bus_addr_q;
  logic [3:0]        bus_be_q;
  logic [31:0]       bus_wdata_q;

  logic              fault_c;
  logic [3:0]        be_c;
  logic [31:0]       wdata_c;
  logic [7:0]        rd_byte_c;
  logic [15:0]       rd_half_c;
  logic [31:0]       rd_ext_c;

  // Alignment / size check and lane steering for the op presented with start
  always_comb begin
    fault_c = 1'b0;
    be_c    = 4'hF;
    wdata_c = wdata;
    unique case (op)
      OP_BYTE: begin
        be_c    = 4'b0001 << addr[1:0];
        wdata_c = {4{wdata[7:0]}};
      end
      OP_HALF: begin
        fault_c = addr[0];
        be_c    = addr[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{wdata[15:0]}};
      end
      OP_WORD: fault_c = (addr[1:0] != 2'b00);
      default: fault_c = 1'b1;
    endcase
  end

  // Extract the addressed lane of the returned word and extend it
  always_comb begin
    rd_byte_c = bus_rdata[7:0];
    unique case (lane_q)
      2'd0:    rd_byte_c = bus_rdata[7:0];
      2'd1:    rd_byte_c = bus_rdata[15:8];
      2'd2:    rd_byte_c = bus_rdata[23:16];
      default: rd_byte_c = bus_rdata[31:24];
    endcase
    rd_half_c = lane_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    unique case (op_q)
      OP_BYTE: rd_ext_c = uns_q ? {24'h0, rd_byte_c} : {{24{rd_byte_c[7]}}, rd_byte_c};
      OP_HALF: rd_ext_c = uns_q ? {16'h0, rd_half_c} : {{16{rd_half_c[15]}}, rd_half_c};
      default: rd_ext_c = bus_rdata;
    endcase
  end

  // Control FSM with all outputs registered
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      op_q        <= 2'b00;
      lane_q      <= 2'b00;
      uns_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      rdata_q     <= 32'h0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 30'h0;
      bus_be_q    <= 4'h0;
      bus_wdata_q <= 32'h0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          error_q <= 1'b0;
          if (start) begin
            op_q   <= op;
            lane_q <= addr[1:0];
            uns_q  <= is_unsigned;
            busy_q <= 1'b1;
            if (fault_c) begin
              error_q <= 1'b1;
              state_q <= S_FINISH;
            end else begin
              bus_req_q   <= 1'b1;
              bus_we_q    <= is_write;
              bus_addr_q  <= addr[31:2];
              bus_be_q    <= be_c;
              bus_wdata_q <= wdata_c;
              cnt_q       <= '0;
              state_q     <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (bus_ack) begin
            bus_req_q <= 1'b0;
            bus_we_q  <= 1'b0;
            error_q   <= bus_err;
            if (!bus_we_q) rdata_q <= bus_err ? 32'h0 : rd_ext_c;
            state_q   <= S_FINISH;
          end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST)) begin
            bus_req_q <= 1'b0;
            bus_we_q  <= 1'b0;
            error_q   <= 1'b1;
            state_q   <= S_FINISH;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_FINISH: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign rdata     = rdata_q;
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_be    = bus_be_q;
  assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_mem_bus_adapter.sv
// Scoreboard bench for mem_bus_adapter: directed cases plus randomized ops
// checked against a behavioural model of the memory-op rules.
module tb_mem_bus_adapter;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, is_write, is_unsigned;
  logic [1:0]  op;
  logic [31:0] addr, wdata;
  logic        busy, done, error;
  logic [31:0] rdata;
  logic        bus_req, bus_we;
  logic [29:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack, bus_err;
  logic [31:0] bus_rdata;

  always #5 clk = ~clk;

  mem_bus_adapter #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .is_write(is_write),
    .is_unsigned(is_unsigned), .op(op), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .rdata(rdata), .error(error),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_err(bus_err), .bus_rdata(bus_rdata)
  );

  typedef struct packed {
    logic        err;
    logic        chk_rd;
    logic [31:0] rd;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] model_rd;
  logic        model_rd_known;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference rules: enables, replicated data and extended read value
  function automatic logic [3:0] m_be(input logic [1:0] o, input logic [31:0] a);
    if (o == 2'b00) return 4'(1 << int'(a[1:0]));
    if (o == 2'b01) return a[1] ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] m_wd(input logic [1:0] o, input logic [31:0] d);
    if (o == 2'b00) return (d & 32'hFF) * 32'h01010101;
    if (o == 2'b01) return (d & 32'hFFFF) * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] m_ext(input logic [1:0] o, input logic [31:0] a,
                                        input logic u, input logic [31:0] w);
    logic [31:0] v;
    if (o == 2'b00) begin
      v = (w >> (8 * int'(a[1:0]))) & 32'hFF;
      if (!u && v >= 32'h80) v = v | 32'hFFFFFF00;
      return v;
    end
    if (o == 2'b01) begin
      v = (w >> (16 * int'(a[1]))) & 32'hFFFF;
      if (!u && v >= 32'h8000) v = v | 32'hFFFF0000;
      return v;
    end
    return w;
  endfunction

  // Monitor: every done pulse must match the oldest expected completion
  always @(negedge clk) begin
    exp_t e;
    if (!reset && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'(done), 32'd0);
      end else begin
        e = sb.pop_front();
        check("done_error", 32'(error), 32'(e.err));
        check("done_busy_low", 32'(busy), 32'd0);
        if (e.chk_rd) check("done_rdata", rdata, e.rd);
      end
    end
  end

  task automatic junk_inputs();
    is_write    = 1'($urandom);
    is_unsigned = 1'($urandom);
    op          = 2'($urandom);
    addr        = $urandom;
    wdata       = $urandom;
  endtask

  // Issue one op, act as the bus with dly wait cycles, check bus side and latency
  task automatic run_op(input logic we, input logic uns, input logic [1:0] o,
                        input logic [31:0] a, input logic [31:0] wd, input int dly,
                        input logic berr, input logic [31:0] brd);
    logic fault;
    exp_t e;
    int   k;
    logic acked;
    fault = (o == 2'b11) || (o == 2'b01 && a[0]) || (o == 2'b10 && a[1:0] != 2'b00);
    e = '0;
    if (fault || dly >= int'(TO)) begin
      e.err = 1'b1; e.chk_rd = 1'b0; model_rd_known = 1'b0;
    end else if (!we) begin
      e.err = berr; e.chk_rd = 1'b1;
      e.rd = berr ? 32'h0 : m_ext(o, a, uns, brd);
      model_rd = e.rd; model_rd_known = 1'b1;
    end else begin
      e.err = berr; e.chk_rd = model_rd_known; e.rd = model_rd;
    end
    sb.push_back(e);

    @(negedge clk);
    start = 1'b1; is_write = we; is_unsigned = uns; op = o; addr = a; wdata = wd;
    @(negedge clk);
    start = 1'b0;
    junk_inputs();
    if (fault) begin
      check("fault_no_req", 32'(bus_req), 32'd0);
      check("fault_busy", 32'(busy), 32'd1);
      start = 1'($urandom);
      @(negedge clk);
      check("fault_done_latency", 32'(done), 32'd1);
      check("fault_no_req2", 32'(bus_req), 32'd0);
      start = 1'b0;
    end else begin
      k = 0; acked = 1'b0;
      while (!acked && k < int'(TO)) begin
        check("req_high", 32'(bus_req), 32'd1);
        check("req_busy", 32'(busy), 32'd1);
        check("bus_we", 32'(bus_we), 32'(we));
        check("bus_addr", 32'(bus_addr), 32'(a[31:2]));
        check("bus_be", 32'(bus_be), 32'(m_be(o, a)));
        check("bus_wdata", bus_wdata, m_wd(o, wd));
        bus_ack   = (k == dly);
        bus_err   = bus_ack ? berr : 1'($urandom);
        bus_rdata = bus_ack ? brd : $urandom;
        start     = 1'($urandom);
        junk_inputs();
        @(negedge clk);
        acked = bus_ack;
        k++;
      end
      bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = $urandom;
      check("req_dropped", 32'(bus_req), 32'd0);
      check("finish_busy", 32'(busy), 32'd1);
      start = 1'($urandom);
      @(negedge clk);
      start = 1'b0;
      check("done_latency", 32'(done), 32'd1);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; is_write = 1'b0; is_unsigned = 1'b0; op = 2'b00;
    addr = 32'h0; wdata = 32'h0; bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = 32'h0;
    model_rd = 32'h0; model_rd_known = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_bus_req", 32'(bus_req), 32'd0);
    check("rst_bus_we", 32'(bus_we), 32'd0);
    check("rst_bus_be", 32'(bus_be), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_bus_addr", 32'(bus_addr), 32'd0);
    check("rst_bus_wdata", bus_wdata, 32'd0);
    reset = 1'b0;

    // Directed cases
    run_op(1'b0, 1'b0, 2'b10, 32'h100, 32'h0, 2, 1'b0, 32'hDEADBEEF);
    run_op(1'b0, 1'b0, 2'b00, 32'h103, 32'h0, 0, 1'b0, 32'h80112233);
    run_op(1'b0, 1'b1, 2'b00, 32'h103, 32'h0, 1, 1'b0, 32'h80112233);
    run_op(1'b1, 1'b0, 2'b01, 32'h22, 32'h0000ABCD, 3, 1'b0, 32'h12345678);
    run_op(1'b0, 1'b0, 2'b10, 32'h2, 32'h0, 0, 1'b0, 32'h0);
    run_op(1'b0, 1'b0, 2'b01, 32'h1, 32'h0, 0, 1'b0, 32'h0);
    run_op(1'b1, 1'b0, 2'b11, 32'h0, 32'h0, 0, 1'b0, 32'h0);
    run_op(1'b0, 1'b0, 2'b10, 32'h44, 32'h0, 0, 1'b0, 32'hCAFEF00D);

    // Timeout, then a stray ack while idle
    run_op(1'b0, 1'b0, 2'b10, 32'h80, 32'h0, 100, 1'b0, 32'h0);
    @(negedge clk); bus_ack = 1'b1; bus_err = 1'b1;
    @(negedge clk); bus_ack = 1'b0; bus_err = 1'b0;
    check("late_ack_no_req", 32'(bus_req), 32'd0);
    check("late_ack_idle", 32'(busy), 32'd0);
    @(negedge clk);
    check("late_ack_no_done", 32'(done), 32'd0);

    // Bus error on a read
    run_op(1'b0, 1'b0, 2'b10, 32'h10, 32'h0, 1, 1'b1, 32'hFFFFFFFF);

    // Reset while the request is outstanding
    @(negedge clk);
    start = 1'b1; is_write = 1'b0; op = 2'b10; addr = 32'h200;
    @(negedge clk);
    start = 1'b0;
    check("pre_rst_req", 32'(bus_req), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midop_rst_req", 32'(bus_req), 32'd0);
    check("midop_rst_busy", 32'(busy), 32'd0);
    check("midop_rst_done", 32'(done), 32'd0);
    reset = 1'b0;
    model_rd = 32'h0; model_rd_known = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_no_done", 32'(done), 32'd0);
    run_op(1'b0, 1'b1, 2'b01, 32'h302, 32'h0, 0, 1'b0, 32'h9ABC1234);

    // Randomized ops
    for (int i = 0; i < 300; i++) begin
      logic [1:0]  ro;
      logic [31:0] ra;
      ro = 2'($urandom);
      if ($urandom_range(0, 9) == 0) ro = 2'b11;
      else if (ro == 2'b11) ro = 2'b10;
      ra = $urandom;
      if ($urandom_range(0, 9) < 8) begin
        if (ro == 2'b01) ra[0] = 1'b0;
        if (ro == 2'b10) ra[1:0] = 2'b00;
      end
      run_op(1'($urandom), 1'($urandom), ro, ra, $urandom,
             int'($urandom_range(0, 5)), ($urandom_range(0, 7) == 0), $urandom);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_bus_adapter.md
Name: mem_bus_adapter

Overview:
- Word-wide bus master directly downstream of the memory access unit. It replaces the simulation-only memory hooks with a synthesizable path.
- Accepts one byte, half-word or word operation at a time and converts it to a single 32-bit bus transaction with byte enables and lane-replicated write data.
- For reads, extracts the addressed lane and sign- or zero-extends it. Reports completion, alignment faults, bus errors and timeouts back to the memory access unit.

Parameters:
TIMEOUT_CYCLES, 255, max cycles bus_req may stay high without bus_ack before the op is aborted with error; 0 disables the timeout
CNT_W, 8, width of the timeout counter; must satisfy TIMEOUT_CYCLES < 2**CNT_W

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
start  input  1  start an operation; accepted only while busy=0
is_write  input  1  1=write, 0=read; sampled with start
is_unsigned  input  1  zero-extend (1) vs sign-extend (0) sub-word reads; sampled with start
op  input  2  size: 00=byte, 01=half, 10=word, 11=invalid; sampled with start
addr  input  32  byte address; sampled with start
wdata  input  32  write data, low bits significant; sampled with start
busy  output  1  operation in flight
done  output  1  one-cycle completion pulse
rdata  output  32  extended read result; valid when done=1 for a read
error  output  1  valid with done: misaligned/invalid op, bus_err or timeout
bus_req  output  1  bus request
bus_we  output  1  bus write strobe
bus_addr  output  30  word address (addr[31:2])
bus_be  output  4  byte enables
bus_wdata  output  32  lane-replicated write data
bus_ack  input  1  transaction complete; sampled only while bus_req=1
bus_err  input  1  bus error; meaningful only with bus_ack
bus_rdata  input  32  read word; valid with bus_ack

Behaviour:
- Reset (synchronous, active-high; clock clk): state IDLE. busy, done, error, bus_req, bus_we all 0. bus_be=0, rdata=0, bus_addr=0, bus_wdata=0, counter=0.
- Reset mid-operation: bus_req drops on the next edge. The in-flight op is abandoned with no done pulse.
- All outputs are registered.
- States:
  - IDLE: start=1 captures the operation and checks it.
    - Fault condition: op=11, op=01 with addr[0]=1, or op=10 with addr[1:0]!=0.
    - On fault: go to FINISH with error=1, busy=1. No bus activity.
    - Otherwise: go to REQ, with bus_req=1, busy=1, counter=0.
  - REQ: bus_req, bus_we, bus_addr, bus_be and bus_wdata are held constant.
    - If bus_ack=1: bus_req->0, go to FINISH.
      - error = bus_err.
      - For a read without error: rdata = extracted value.
      - For a read with bus_err=1: rdata = 0.
      - For a write: rdata is unchanged.
    - If bus_ack=0, TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1: bus_req->0, error=1, go to FINISH.
    - Otherwise: counter increments.
  - FINISH: done=1 and busy=0 for exactly one cycle, then IDLE. done=0, error=0 in IDLE.
- start is ignored while busy=1 and during the FINISH cycle.
- Latency:
  - start at edge N -> bus_req high after edge N.
  - bus_ack sampled at edge M -> done/rdata/error valid after edge M+1.
  - A zero-wait-state bus (ack in the first REQ cycle) gives 3 cycles from start to done.
  - A faulting op gives done after the 2nd edge.
- Byte lanes (L=addr[1:0]):
  - Byte: bus_be=1<<L; bus_wdata={4{wdata[7:0]}}.
  - Half: bus_be = addr[1] ? 1100 : 0011; bus_wdata={2{wdata[15:0]}}.
  - Word: bus_be=1111; bus_wdata=wdata.
  - bus_be and bus_wdata are also driven for reads; the bus ignores bus_wdata on reads.
- Read extraction:
  - Byte: bus_rdata[8L+7:8L].
  - Half: bus_rdata[16*addr[1]+15 : 16*addr[1]].
  - Sub-word values are sign-extended unless is_unsigned=1; is_unsigned is ignored for words.
- bus_ack while bus_req=0 is ignored.
- bus_err without bus_ack is ignored.

Test Plan:
- Aligned word read: start, op=10, addr=0x100. bus_ack with bus_rdata=0xDEADBEEF after 2 wait cycles -> bus_addr=0x40, bus_be=1111, done one cycle after ack, rdata=0xDEADBEEF, error=0.
- Signed/unsigned byte read: addr=0x103, bus_rdata=0x80112233.
  - is_unsigned=0 -> bus_be=1000, rdata=0xFFFFFF80.
  - is_unsigned=1 -> rdata=0x00000080.
- Half write: op=01, addr=0x22, wdata=0x0000ABCD -> bus_we=1, bus_be=1100, bus_wdata=0xABCDABCD; signals stable until ack; rdata unchanged.
- Faults: op=10 addr=0x2; op=01 addr=0x1; op=11 -> no bus_req ever, done+error after 2 edges; a following legal op completes normally.
- Timeout: TIMEOUT_CYCLES=4, never ack -> bus_req high exactly 4 cycles, then done=1 and error=1; a late bus_ack in IDLE is ignored.
- Bus error and reset:
  - Read acked with bus_err=1 -> error=1, rdata=0.
  - Separately, reset asserted while in REQ -> bus_req and busy low after that edge, no done; a start after reset proceeds normally.
  - start pulses while busy are ignored; exactly one done per accepted start.
